// File: rtl/cam_read_pkg.sv
// rtl/cam_read_pkg.sv - shared camera capture types, default geometry and RGB111 bit positions
package cam_read_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_WAIT_FRAME,
        ST_BYTE1,
        ST_BYTE2
    } cam_state_t;

    localparam int DEF_AW    = 15;
    localparam int DEF_DW    = 3;
    localparam int DEF_IMG_W = 160;
    localparam int DEF_IMG_H = 120;

    // RGB111 output bit positions
    localparam int RGB_R_BIT = 2;
    localparam int RGB_G_BIT = 1;
    localparam int RGB_B_BIT = 0;

    // Source bits: R and G from the high byte, B from the low byte of RGB565
    localparam int SRC_R_BIT = 7;
    localparam int SRC_G_BIT = 2;
    localparam int SRC_B_BIT = 4;

    // Column counter keeps at least 8 bits so the colour-bar field col[7:5] exists
    function automatic int col_width(input int img_w);
        return ($clog2(img_w) > 8) ? $clog2(img_w) : 8;
    endfunction

endpackage

// File: rtl/rgb565_to_rgb111.sv
// rtl/rgb565_to_rgb111.sv - combinational RGB565 byte pair to RGB111 pixel
module rgb565_to_rgb111
    import cam_read_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic [7:0]    byte_hi,
    input  logic [7:0]    byte_lo,
    output logic [DW-1:0] px
);

    logic unused_bits;
    assign unused_bits = ^{byte_hi, byte_lo};

    always_comb begin
        px            = '0;
        px[RGB_R_BIT] = byte_hi[SRC_R_BIT];
        px[RGB_G_BIT] = byte_hi[SRC_G_BIT];
        px[RGB_B_BIT] = byte_lo[SRC_B_BIT];
    end

endmodule

// File: rtl/cam_read.sv
// rtl/cam_read.sv - camera byte-stream capture into an RGB111 frame buffer; CAM_TEST_PATTERN_EN selects colour bars
module cam_read
    import cam_read_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    px_data,
    input  logic          href,
    input  logic          vsync,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic          overflow
);

    localparam int              CW        = col_width(IMG_W);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(IMG_W * IMG_H - 1);
    localparam logic [CW-1:0]   LAST_COL  = CW'(IMG_W - 1);

    if (IMG_W * IMG_H > 2 ** AW) begin : g_bad_size
        $error("cam_read: IMG_W*IMG_H does not fit in AW address bits");
    end

    cam_state_t    state;
    logic          vsync_q;
    logic          href_q;
    logic [7:0]    byte1;
    logic [CW-1:0] col;
    logic          full;
    logic [DW-1:0] conv_px;
    logic [DW-1:0] next_px;

    rgb565_to_rgb111 #(.DW(DW)) u_conv (
        .byte_hi (byte1),
        .byte_lo (px_data),
        .px      (conv_px)
    );

`ifdef CAM_TEST_PATTERN_EN
    logic unused_conv;
    assign unused_conv = ^conv_px;
    assign next_px     = DW'(col[7:5]);
`else
    assign next_px = conv_px;
`endif

    logic vsync_rise, vsync_fall, href_fall;
    assign vsync_rise = vsync & ~vsync_q;
    assign vsync_fall = ~vsync & vsync_q;
    assign href_fall  = ~href & href_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            byte1       <= '0;
            col         <= '0;
            full        <= 1'b0;
            mem_px_addr <= '0;
            mem_px_data <= '0;
            px_wr       <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            href_q     <= href;
            px_wr      <= 1'b0;
            frame_done <= 1'b0;

            // Address advances the cycle after a write; the last slot latches full instead of wrapping
            if (px_wr) begin
                if (mem_px_addr == LAST_ADDR) full <= 1'b1;
                else                          mem_px_addr <= mem_px_addr + 1'b1;
            end

            if (href_fall) col <= '0;

            case (state)
                ST_INIT: begin
                    if (vsync) state <= ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    if (vsync_fall) begin
                        state       <= ST_BYTE1;
                        mem_px_addr <= '0;
                        full        <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                ST_BYTE1: begin
                    if (vsync_rise) begin
                        frame_done <= 1'b1;
                        state      <= ST_WAIT_FRAME;
                    end else if (href) begin
                        byte1 <= px_data;
                        state <= ST_BYTE2;
                    end
                end
                ST_BYTE2: begin
                    if (vsync_rise) begin
                        frame_done <= 1'b1;
                        state      <= ST_WAIT_FRAME;
                    end else begin
                        state <= ST_BYTE1;
                        if (href) begin
                            if (full) begin
                                overflow <= 1'b1;
                            end else begin
                                px_wr       <= 1'b1;
                                mem_px_data <= next_px;
                                col         <= (col == LAST_COL) ? '0 : col + 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_read.sv
// tb/tb_cam_read.sv - randomized self-checking bench for cam_read against a pixel-list model
module tb_cam_read;

    localparam int AW    = 15;
    localparam int DW    = 3;
    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int NPIX  = IMG_W * IMG_H;
`ifdef CAM_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    px_data;
    logic          href;
    logic          vsync;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;
    logic          frame_done;
    logic          overflow;

    always #5 clk = ~clk;

    cam_read #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk         (clk),
        .reset       (reset),
        .px_data     (px_data),
        .href        (href),
        .vsync       (vsync),
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .px_wr       (px_wr),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    int checks = 0;
    int passed = 0;

    logic [AW+DW-1:0] got_q[$];
    logic [AW+DW-1:0] exp_q[$];
    int               fd_cnt = 0;

    // Model: pixels are numbered in arrival order; address is the pixel index until the buffer is full
    int m_cnt;
    bit m_ovf;

    always @(negedge clk) begin
        if (px_wr)      got_q.push_back({mem_px_addr, mem_px_data});
        if (frame_done) fd_cnt++;
    end

    task automatic step(input logic v, input logic h, input logic [7:0] d);
        vsync   = v;
        href    = h;
        px_data = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] model_px(input logic [7:0] b0, input logic [7:0] b1, input int column);
        return TP ? DW'(column / 32) : {b0[7], b0[2], b1[4]};
    endfunction

    task automatic start_frame();
        repeat (3) step(1'b1, 1'b0, 8'h00);
        repeat (2) step(1'b0, 1'b0, 8'h00);
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic end_frame();
        repeat (3) step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic send_line(input logic [7:0] bytes[$]);
        int column = 0;
        for (int i = 0; i < bytes.size(); i++) begin
            step(1'b0, 1'b1, bytes[i]);
            if (i % 2 == 1) begin
                if (m_cnt < NPIX) begin
                    exp_q.push_back({AW'(m_cnt), model_px(bytes[i-1], bytes[i], column)});
                    m_cnt++;
                    column = (column + 1) % IMG_W;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        repeat (2) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic rand_line(input int n);
        logic [7:0] b[$];
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        send_line(b);
    endtask

    task automatic test_reset();
        checks++; if (mem_px_addr !== '0) $display("FAIL reset_addr got %0d want 0", mem_px_addr); else passed++;
        checks++; if (mem_px_data !== '0) $display("FAIL reset_data got %0d want 0", mem_px_data); else passed++;
        checks++; if (px_wr !== 1'b0) $display("FAIL reset_px_wr got %0b want 0", px_wr); else passed++;
        checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %0b want 0", frame_done); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else passed++;
        reset = 1'b0;
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_basic();
        logic [7:0] b[$];
        int g0 = got_q.size();
        int e0 = exp_q.size();
        int f0 = fd_cnt;
        b = {8'hF8, 8'h00, 8'h07, 8'hE0};
        start_frame();
        send_line(b);
        end_frame();
        checks++;
        if (got_q.size() - g0 != 2) $display("FAIL basic_count got %0d want 2", got_q.size() - g0); else passed++;
        for (int i = 0; i < 2 && g0 + i < got_q.size(); i++) begin
            checks++;
            if (got_q[g0+i] !== exp_q[e0+i])
                $display("FAIL basic_write[%0d] got %h want %h", i, got_q[g0+i], exp_q[e0+i]);
            else passed++;
        end
        if (!TP) begin
            checks++;
            if (g0 + 1 < got_q.size() && got_q[g0+1] !== {AW'(1), 3'b010})
                $display("FAIL basic_second_pixel got %h want %h", got_q[g0+1], {AW'(1), 3'b010});
            else passed++;
        end
        checks++; if (fd_cnt - f0 != 1) $display("FAIL basic_frame_done got %0d want 1", fd_cnt - f0); else passed++;
    endtask

    task automatic test_odd_bytes();
        int g0 = got_q.size();
        int e0 = exp_q.size();
        start_frame();
        rand_line(3);
        checks++;
        if (got_q.size() - g0 != 1) $display("FAIL odd_count got %0d want 1", got_q.size() - g0); else passed++;
        rand_line(4);
        end_frame();
        checks++;
        if (got_q.size() - g0 != exp_q.size() - e0)
            $display("FAIL odd_total got %0d want %0d", got_q.size() - g0, exp_q.size() - e0);
        else passed++;
        for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
            checks++;
            if (got_q[g0+i] !== exp_q[e0+i])
                $display("FAIL odd_write[%0d] got %h want %h", i, got_q[g0+i], exp_q[e0+i]);
            else passed++;
        end
    endtask

    task automatic test_random_lines();
        int g0 = got_q.size();
        int e0 = exp_q.size();
        int f0 = fd_cnt;
        start_frame();
        for (int l = 0; l < 8; l++) rand_line($urandom_range(1, 24));
        end_frame();
        checks++;
        if (got_q.size() - g0 != exp_q.size() - e0)
            $display("FAIL rand_count got %0d want %0d", got_q.size() - g0, exp_q.size() - e0);
        else passed++;
        for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
            checks++;
            if (got_q[g0+i] !== exp_q[e0+i])
                $display("FAIL rand_write[%0d] got %h want %h", i, got_q[g0+i], exp_q[e0+i]);
            else passed++;
        end
        checks++; if (fd_cnt - f0 != 1) $display("FAIL rand_frame_done got %0d want 1", fd_cnt - f0); else passed++;
    endtask

    task automatic test_full_frame();
        int g0 = got_q.size();
        int e0 = exp_q.size();
        int f0 = fd_cnt;
        int g1;
        start_frame();
        for (int l = 0; l < IMG_H; l++) rand_line(2 * IMG_W);
        checks++;
        if (got_q.size() - g0 != NPIX) $display("FAIL full_count got %0d want %0d", got_q.size() - g0, NPIX); else passed++;
        for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
            checks++;
            if (got_q[g0+i] !== exp_q[e0+i])
                $display("FAIL full_write[%0d] got %h want %h", i, got_q[g0+i], exp_q[e0+i]);
            else passed++;
        end
        checks++; if (mem_px_addr !== AW'(NPIX - 1)) $display("FAIL full_last_addr got %0d want %0d", mem_px_addr, NPIX - 1); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL full_overflow got %0b want 0", overflow); else passed++;
        g1 = got_q.size();
        rand_line(2);
        checks++; if (got_q.size() != g1) $display("FAIL extra_px_wr got %0d want 0", got_q.size() - g1); else passed++;
        checks++; if (overflow !== m_ovf) $display("FAIL extra_overflow got %0b want %0b", overflow, m_ovf); else passed++;
        checks++; if (mem_px_addr !== AW'(NPIX - 1)) $display("FAIL extra_addr got %0d want %0d", mem_px_addr, NPIX - 1); else passed++;
        end_frame();
        checks++; if (fd_cnt - f0 != 1) $display("FAIL full_frame_done got %0d want 1", fd_cnt - f0); else passed++;
    endtask

    task automatic test_reset_midline();
        int g0;
        int e0;
        int f0;
        start_frame();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom));
        reset = 1'b1;
        f0 = fd_cnt;
        step(1'b0, 1'b1, 8'($urandom));
        checks++; if (mem_px_addr !== '0) $display("FAIL midrst_addr got %0d want 0", mem_px_addr); else passed++;
        checks++; if (mem_px_data !== '0) $display("FAIL midrst_data got %0d want 0", mem_px_data); else passed++;
        checks++; if (px_wr !== 1'b0) $display("FAIL midrst_px_wr got %0b want 0", px_wr); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL midrst_overflow got %0b want 0", overflow); else passed++;
        reset = 1'b0;
        g0 = got_q.size();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'($urandom));
        repeat (2) step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'($urandom));
        repeat (2) step(1'b0, 1'b0, 8'h00);
        checks++; if (got_q.size() != g0) $display("FAIL midrst_no_writes got %0d want 0", got_q.size() - g0); else passed++;
        checks++; if (fd_cnt != f0) $display("FAIL midrst_frame_done got %0d want 0", fd_cnt - f0); else passed++;
        g0 = got_q.size();
        e0 = exp_q.size();
        start_frame();
        rand_line(6);
        end_frame();
        checks++;
        if (got_q.size() - g0 != 3) $display("FAIL resume_count got %0d want 3", got_q.size() - g0); else passed++;
        for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
            checks++;
            if (got_q[g0+i] !== exp_q[e0+i])
                $display("FAIL resume_write[%0d] got %h want %h", i, got_q[g0+i], exp_q[e0+i]);
            else passed++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        vsync   = 1'b0;
        href    = 1'b0;
        px_data = 8'h00;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_odd_bytes();
        test_random_lines();
        test_full_frame();
        test_reset_midline();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cam_read.md
CAM_READ -- requirements
Module: cam_read

Interface
REQ-001 SHALL have parameter AW, default 15, frame-buffer address width.
REQ-002 SHALL have parameter DW, default 3, pixel width in RGB111 (R=bit2, G=bit1, B=bit0).
REQ-003 SHALL have parameter IMG_W, default 160, pixels per line.
REQ-004 SHALL have parameter IMG_H, default 120, lines per frame.
REQ-005 SHALL run on one clock with synchronous, active-high reset; all logic samples on the rising edge of clk.
REQ-006 clk  input  1  system clock; camera signals are sampled on it.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 px_data  input  8  camera byte bus, RGB565, high byte first.
REQ-009 href  input  1  line-valid; high while pixel bytes are on px_data.
REQ-010 vsync  input  1  frame sync; high between frames.
REQ-011 mem_px_addr  output  AW  write address to the frame buffer.
REQ-012 mem_px_data  output  DW  RGB111 pixel to the frame buffer.
REQ-013 px_wr  output  1  one-cycle write strobe; address and data are valid while it is high.
REQ-014 frame_done  output  1  one-cycle pulse at the end of a frame.
REQ-015 overflow  output  1  sticky flag; set when pixels arrive beyond IMG_W*IMG_H.

Function
REQ-016 The FSM SHALL have four states: INIT, WAIT_FRAME, BYTE1, BYTE2.
REQ-017 INIT SHALL go to WAIT_FRAME on the first cycle with vsync=1.
REQ-018 WAIT_FRAME SHALL go to BYTE1 on a vsync 1->0 edge (registered previous value) and clear the address to 0.
REQ-019 BYTE1 with href=1 SHALL latch px_data into a first-byte register and go to BYTE2.
REQ-020 BYTE2 with href=1 SHALL form the pixel R=byte1[7], G=byte1[2], B=px_data[4] and go to BYTE1.
REQ-021 In BYTE2 with href=1, px_wr SHALL assert for that one cycle with mem_px_data equal to the formed pixel, and mem_px_addr SHALL increment on the next cycle.
REQ-022 Write latency SHALL be 1 clk from the second-byte sample to px_wr high, with registered outputs.
REQ-023 If href falls in BYTE2, the partial byte SHALL be discarded, no write SHALL occur, and the FSM SHALL return to BYTE1.
REQ-024 In BYTE1 or BYTE2, a vsync 0->1 edge SHALL pulse frame_done for one cycle, take priority over href, and move the FSM to WAIT_FRAME.
REQ-025 When mem_px_addr = IMG_W*IMG_H-1 has been written, further pixels SHALL be dropped with no px_wr, overflow SHALL set, and the address SHALL hold; there is no wrap.
REQ-026 The address counter SHALL be AW bits wide; IMG_W*IMG_H SHALL be at most 2**AW, checked at elaboration.
REQ-027 A column counter (0..IMG_W-1) SHALL increment per written pixel and clear on an href 1->0 edge or when it reaches IMG_W-1.

Reset
REQ-028 On reset the FSM SHALL go to INIT; mem_px_addr, mem_px_data, px_wr, frame_done, overflow, the column counter and the byte register SHALL be 0.
REQ-029 A reset mid-frame SHALL abort the frame with no frame_done; capture SHALL resume only after the next complete vsync high->low sequence.
REQ-030 overflow SHALL clear only on reset or on entry to BYTE1 from WAIT_FRAME.

Configuration
REQ-031 With macro CAM_TEST_PATTERN_EN defined, mem_px_data SHALL be column[7:5] (colour bars) in place of camera data; timing, addresses and strobes SHALL be unchanged.
REQ-032 Without CAM_TEST_PATTERN_EN, mem_px_data SHALL be the RGB565->RGB111 conversion of REQ-020.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration, the default IMG_W/IMG_H/AW/DW constants, and the RGB111 bit positions.
REQ-034 A sub-module rgb565_to_rgb111 (combinational, two bytes in, DW out) SHALL perform the conversion.
REQ-035 The FSM, counters and edge detectors SHALL remain in cam_read.

Verification
REQ-036 Reset, then vsync high then low, then one href line of 2 pixels with bytes F8,00,07,E0 SHALL give writes addr0=3'b100 and addr1=3'b010.
REQ-037 A full 160x120 frame followed by vsync rising SHALL give exactly 19200 px_wr pulses, last address 19199, one frame_done, and overflow=0.
REQ-038 One extra pixel beyond 19200 SHALL give no px_wr, overflow=1, and the address held at 19199.
REQ-039 href dropping after an odd byte (3 bytes) SHALL give 1 write only, with the next line starting cleanly at the byte-1 phase.
REQ-040 Reset asserted mid-line SHALL zero all outputs; the following href data without a new vsync high->low SHALL give no writes.
REQ-041 With CAM_TEST_PATTERN_EN, pixels at column 0, 32 and 159 SHALL give mem_px_data 0, 1 and 4 respectively.
